ram_stream_reader: RTL and testbench



---
 rtl/ram_stream_reader.sv | 147 ++++++++++++++
 tb/tb_ram_stream_reader.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_stream_reader.sv
// Sweeps an address window of an async-read RAM and streams each word on a valid/ready port.
// Optional READER_REPEAT_EN adds repeat_mode to restart the window after each pass.
module ram_stream_reader #(
   parameter int RAM_WIDTH     = 8,
   parameter int RAM_ADDR_BITS = 4
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     start,
   input  logic [RAM_ADDR_BITS-1:0] base_addr,
   input  logic [RAM_ADDR_BITS:0]   length,
`ifdef READER_REPEAT_EN
   input  logic                     repeat_mode,
`endif
   output logic [RAM_ADDR_BITS-1:0] read_addr,
   input  logic [RAM_WIDTH-1:0]     ram_data,
   output logic [RAM_WIDTH-1:0]     m_tdata,
   output logic                     m_tvalid,
   input  logic                     m_tready,
   output logic                     m_tlast,
   output logic                     busy,
   output logic                     done
);

   typedef enum logic {IDLE, STREAM} state_t;

   localparam logic [RAM_ADDR_BITS:0] DEPTH = {1'b1, {RAM_ADDR_BITS{1'b0}}};

   state_t                   state_q, state_d;
   logic [RAM_ADDR_BITS-1:0] addr_q, addr_d;
   logic [RAM_ADDR_BITS:0]   rem_q, rem_d;
   logic [RAM_WIDTH-1:0]     tdata_q, tdata_d;
   logic                     tvalid_q, tvalid_d;
   logic                     tlast_q, tlast_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;
   logic [RAM_ADDR_BITS:0]   len_clamped;
   logic                     hs;
`ifdef READER_REPEAT_EN
   logic [RAM_ADDR_BITS-1:0] base_q, base_d;
   logic [RAM_ADDR_BITS:0]   len_q, len_d;
`endif

   assign len_clamped = (length > DEPTH) ? DEPTH : length;
   assign hs          = tvalid_q & m_tready;

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      rem_d    = rem_q;
      tdata_d  = tdata_q;
      tvalid_d = tvalid_q;
      tlast_d  = tlast_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
`ifdef READER_REPEAT_EN
      base_d   = base_q;
      len_d    = len_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (length == '0) begin
                  done_d = 1'b1;
               end else begin
                  addr_d  = base_addr;
                  rem_d   = len_clamped;
                  busy_d  = 1'b1;
                  state_d = STREAM;
`ifdef READER_REPEAT_EN
                  base_d  = base_addr;
                  len_d   = len_clamped;
`endif
               end
            end
         end
         STREAM: begin
            if ((rem_q != '0) && (!tvalid_q || m_tready)) begin
               tdata_d  = ram_data;
               tvalid_d = 1'b1;
               tlast_d  = (rem_q == {{RAM_ADDR_BITS{1'b0}}, 1'b1});
               addr_d   = addr_q + 1'b1;
               rem_d    = rem_q - 1'b1;
            end else if (hs) begin
               tvalid_d = 1'b0;
               tlast_d  = 1'b0;
            end
            // rem is already 0 on the last handshake, so a reload here yields one bubble cycle
            if (hs && tlast_q) begin
`ifdef READER_REPEAT_EN
               if (repeat_mode) begin
                  addr_d = base_q;
                  rem_d  = len_q;
               end else begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
`else
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         rem_q    <= '0;
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef READER_REPEAT_EN
         base_q   <= '0;
         len_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         rem_q    <= rem_d;
         tdata_q  <= tdata_d;
         tvalid_q <= tvalid_d;
         tlast_q  <= tlast_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef READER_REPEAT_EN
         base_q   <= base_d;
         len_q    <= len_d;
`endif
      end
   end

   assign read_addr = addr_q;
   assign m_tdata   = tdata_q;
   assign m_tvalid  = tvalid_q;
   assign m_tlast   = tlast_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader against a behavioural async-read RAM preloaded with A0+k.
module tb_ram_stream_reader;

   logic       clk = 1'b0;
   logic       resetn;
   logic       start;
   logic [3:0] base_addr;
   logic [4:0] length;
   logic [3:0] read_addr;
   logic [7:0] ram_data;
   logic [7:0] m_tdata;
   logic       m_tvalid;
   logic       m_tready;
   logic       m_tlast;
   logic       busy;
   logic       done;
`ifdef READER_REPEAT_EN
   logic       repeat_mode;
`endif

   logic [7:0] mem [16];
   int unsigned pass_cnt = 0;
   int unsigned total_cnt = 0;

   assign ram_data = mem[read_addr];

   always #5 clk = ~clk;

   ram_stream_reader #(.RAM_WIDTH(8), .RAM_ADDR_BITS(4)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .start     (start),
      .base_addr (base_addr),
      .length    (length),
`ifdef READER_REPEAT_EN
      .repeat_mode (repeat_mode),
`endif
      .read_addr (read_addr),
      .ram_data  (ram_data),
      .m_tdata   (m_tdata),
      .m_tvalid  (m_tvalid),
      .m_tready  (m_tready),
      .m_tlast   (m_tlast),
      .busy      (busy),
      .done      (done)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_sweep(input logic [3:0] b, input logic [4:0] l);
      base_addr = b;
      length    = l;
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      tick();
      tick();
      total_cnt++;
      if ({read_addr, m_tdata, m_tvalid, m_tlast, busy, done} !== 16'h0)
         $display("FAIL reset_outputs: got addr=%0d data=%h v=%b l=%b busy=%b done=%b, want all 0",
                  read_addr, m_tdata, m_tvalid, m_tlast, busy, done);
      else pass_cnt++;
      resetn = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      m_tready = 1'b1;
      start_sweep(4'd3, 5'd4);
      total_cnt++;
      if (m_tvalid !== 1'b0 || busy !== 1'b1 || read_addr !== 4'd3)
         $display("FAIL basic_e0: got v=%b busy=%b addr=%0d, want v=0 busy=1 addr=3", m_tvalid, busy, read_addr);
      else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         tick();
         total_cnt++;
         if (m_tvalid !== 1'b1 || m_tdata !== 8'hA3 + 8'(i) || m_tlast !== (i == 3) || busy !== 1'b1 || done !== 1'b0)
            $display("FAIL basic_beat%0d: got v=%b d=%h l=%b busy=%b done=%b, want v=1 d=%h l=%b busy=1 done=0",
                     i, m_tvalid, m_tdata, m_tlast, busy, done, 8'hA3 + 8'(i), (i == 3));
         else pass_cnt++;
      end
      tick();
      total_cnt++;
      if (done !== 1'b1 || busy !== 1'b0 || m_tvalid !== 1'b0 || m_tlast !== 1'b0)
         $display("FAIL basic_done: got done=%b busy=%b v=%b l=%b, want done=1 busy=0 v=0 l=0", done, busy, m_tvalid, m_tlast);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (done !== 1'b0)
         $display("FAIL basic_done_pulse: got done=%b, want 0", done);
      else pass_cnt++;
   endtask

   task automatic test_stall();
      logic       pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [7:0] pre_d;
      logic       pre_v, pre_r, pre_l;
      int         idx = 0;
      int         ndone = 0;
      int         stall_err = 0;
      int         order_err = 0;
      m_tready = 1'b1;
      start_sweep(4'd3, 5'd4);
      for (int cyc = 0; cyc < 40 && ndone == 0; cyc++) begin
         m_tready = pat[cyc % 6];
         #1;
         pre_d = m_tdata; pre_v = m_tvalid; pre_r = m_tready; pre_l = m_tlast;
         tick();
         if (pre_v && pre_r) begin
            if (idx > 3 || pre_d !== 8'hA3 + 8'(idx) || pre_l !== (idx == 3)) begin
               order_err++;
               $display("FAIL stall_beat%0d: got d=%h l=%b, want d=%h l=%b", idx, pre_d, pre_l, 8'hA3 + 8'(idx), (idx == 3));
            end
            idx++;
         end else if (pre_v && !pre_r) begin
            if (m_tvalid !== 1'b1 || m_tdata !== pre_d || m_tlast !== pre_l) begin
               stall_err++;
               $display("FAIL stall_hold: got v=%b d=%h l=%b, want v=1 d=%h l=%b", m_tvalid, m_tdata, m_tlast, pre_d, pre_l);
            end
         end
         if (done === 1'b1) ndone++;
      end
      total_cnt++;
      if (order_err != 0) $display("FAIL stall_order: got %0d bad beats, want 0", order_err);
      else pass_cnt++;
      total_cnt++;
      if (stall_err != 0) $display("FAIL stall_stable: got %0d unstable cycles, want 0", stall_err);
      else pass_cnt++;
      total_cnt++;
      if (idx != 4 || ndone != 1 || busy !== 1'b0)
         $display("FAIL stall_count: got beats=%0d done=%0d busy=%b, want beats=4 done=1 busy=0", idx, ndone, busy);
      else pass_cnt++;
      m_tready = 1'b1;
      tick();
   endtask

   task automatic test_wrap();
      logic [3:0] ea [4] = '{4'd14, 4'd15, 4'd0, 4'd1};
      logic [7:0] ed [4] = '{8'hAE, 8'hAF, 8'hA0, 8'hA1};
      int         err = 0;
      m_tready = 1'b1;
      start_sweep(4'd14, 5'd4);
      for (int i = 0; i < 4; i++) begin
         if (read_addr !== ea[i]) begin
            err++;
            $display("FAIL wrap_addr%0d: got %0d, want %0d", i, read_addr, ea[i]);
         end
         tick();
         if (m_tvalid !== 1'b1 || m_tdata !== ed[i]) begin
            err++;
            $display("FAIL wrap_data%0d: got v=%b d=%h, want v=1 d=%h", i, m_tvalid, m_tdata, ed[i]);
         end
      end
      total_cnt++;
      if (err != 0) $display("FAIL wrap: got %0d errors, want 0", err);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (done !== 1'b1) $display("FAIL wrap_done: got done=%b, want 1", done);
      else pass_cnt++;
      tick();
   endtask

   task automatic test_zero_len();
      start_sweep(4'd5, 5'd0);
      total_cnt++;
      if (done !== 1'b1 || busy !== 1'b0 || m_tvalid !== 1'b0)
         $display("FAIL zero_len_done: got done=%b busy=%b v=%b, want done=1 busy=0 v=0", done, busy, m_tvalid);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (done !== 1'b0 || busy !== 1'b0 || m_tvalid !== 1'b0)
         $display("FAIL zero_len_after: got done=%b busy=%b v=%b, want all 0", done, busy, m_tvalid);
      else pass_cnt++;
   endtask

   task automatic test_clamp();
      int beats = 0;
      int lasts = 0;
      int ndone = 0;
      logic [7:0] last_d = 8'h00;
      m_tready = 1'b1;
      start_sweep(4'd0, 5'd20);
      for (int cyc = 0; cyc < 40 && ndone == 0; cyc++) begin
         tick();
         if (m_tvalid === 1'b1) beats++;
         if (m_tlast === 1'b1) begin
            lasts++;
            last_d = m_tdata;
         end
         if (done === 1'b1) ndone++;
      end
      total_cnt++;
      if (beats != 16 || lasts != 1 || last_d !== 8'hAF || ndone != 1)
         $display("FAIL clamp: got beats=%0d lasts=%0d last=%h done=%0d, want 16 1 af 1", beats, lasts, last_d, ndone);
      else pass_cnt++;
      tick();
   endtask

   task automatic test_reset_mid();
      int ndone = 0;
      m_tready = 1'b1;
      start_sweep(4'd2, 5'd6);
      tick();
      tick();
      total_cnt++;
      if (m_tvalid !== 1'b1 || m_tdata !== 8'hA3)
         $display("FAIL reset_mid_pre: got v=%b d=%h, want v=1 d=a3", m_tvalid, m_tdata);
      else pass_cnt++;
      resetn = 1'b0;
      tick();
      total_cnt++;
      if (m_tvalid !== 1'b0 || busy !== 1'b0 || read_addr !== 4'd0 || done !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== 8'h00)
         $display("FAIL reset_mid: got v=%b busy=%b addr=%0d done=%b l=%b d=%h, want all 0",
                  m_tvalid, busy, read_addr, done, m_tlast, m_tdata);
      else pass_cnt++;
      resetn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (done === 1'b1 || m_tvalid === 1'b1) ndone++;
      end
      total_cnt++;
      if (ndone != 0) $display("FAIL reset_mid_quiet: got %0d active cycles, want 0", ndone);
      else pass_cnt++;
      start_sweep(4'd5, 5'd2);
      tick();
      total_cnt++;
      if (m_tvalid !== 1'b1 || m_tdata !== 8'hA5 || m_tlast !== 1'b0)
         $display("FAIL restart_beat0: got v=%b d=%h l=%b, want v=1 d=a5 l=0", m_tvalid, m_tdata, m_tlast);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (m_tvalid !== 1'b1 || m_tdata !== 8'hA6 || m_tlast !== 1'b1)
         $display("FAIL restart_beat1: got v=%b d=%h l=%b, want v=1 d=a6 l=1", m_tvalid, m_tdata, m_tlast);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (done !== 1'b1 || busy !== 1'b0)
         $display("FAIL restart_done: got done=%b busy=%b, want done=1 busy=0", done, busy);
      else pass_cnt++;
      tick();
   endtask

`ifdef READER_REPEAT_EN
   task automatic test_repeat();
      logic [7:0] ed [6] = '{8'hA0, 8'hA1, 8'h00, 8'hA0, 8'hA1, 8'h00};
      logic       ev [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      logic       el [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      logic       eb [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic       edn[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      int         err = 0;
      m_tready    = 1'b1;
      repeat_mode = 1'b1;
      start_sweep(4'd0, 5'd2);
      for (int i = 0; i < 6; i++) begin
         tick();
         if (i == 3) repeat_mode = 1'b0;
         if (m_tvalid !== ev[i] || (ev[i] && m_tdata !== ed[i]) || m_tlast !== el[i] || busy !== eb[i] || done !== edn[i]) begin
            err++;
            $display("FAIL repeat_cyc%0d: got v=%b d=%h l=%b busy=%b done=%b, want v=%b d=%h l=%b busy=%b done=%b",
                     i, m_tvalid, m_tdata, m_tlast, busy, done, ev[i], ed[i], el[i], eb[i], edn[i]);
         end
      end
      total_cnt++;
      if (err != 0) $display("FAIL repeat: got %0d errors, want 0", err);
      else pass_cnt++;
      tick();
   endtask
`endif

   initial begin
      for (int k = 0; k < 16; k++) mem[k] = 8'hA0 + 8'(k);
      resetn    = 1'b0;
      start     = 1'b0;
      base_addr = '0;
      length    = '0;
      m_tready  = 1'b0;
`ifdef READER_REPEAT_EN
      repeat_mode = 1'b0;
`endif
      test_reset();
      test_basic();
      test_stall();
      test_wrap();
      test_zero_len();
      test_clamp();
      test_reset_mid();
`ifdef READER_REPEAT_EN
      test_repeat();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
